// File: rtl/bram_port_arbiter_if.sv
// Bus bundle between the two BRAM requesters, the arbiter and the BRAM port B.
// The master side is the requester/BRAM environment; the slave side is the arbiter.
interface bram_port_arbiter_if #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 10
);
    logic                  r0_req;
    logic [ADDR_WIDTH-1:0] r0_addr;
    logic                  r0_gnt;
    logic                  r0_rvalid;
    logic [WIDTH-1:0]      r0_rdata;

    logic                  r1_req;
    logic                  r1_we;
    logic [ADDR_WIDTH-1:0] r1_addr;
    logic [WIDTH-1:0]      r1_wdata;
    logic                  r1_gnt;
    logic                  r1_rvalid;
    logic [WIDTH-1:0]      r1_rdata;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_data;
    logic                  mem_we;
    logic [WIDTH-1:0]      mem_q;

    modport master (
        output r0_req, r0_addr, r1_req, r1_we, r1_addr, r1_wdata, mem_q,
        input  r0_gnt, r0_rvalid, r0_rdata, r1_gnt, r1_rvalid, r1_rdata,
               mem_addr, mem_data, mem_we
    );

    modport slave (
        input  r0_req, r0_addr, r1_req, r1_we, r1_addr, r1_wdata, mem_q,
        output r0_gnt, r0_rvalid, r0_rdata, r1_gnt, r1_rvalid, r1_rdata,
               mem_addr, mem_data, mem_we
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Shares BRAM port B between the VGA pixel fetch (r0, priority) and an auxiliary
// read/write master (r1), one access per clock, with a starvation guard for r1.
module bram_port_arbiter #(
    parameter int WIDTH        = 16,
    parameter int ADDR_WIDTH   = 10,
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    bram_port_arbiter_if.slave   bus,
    output logic [CNT_WIDTH-1:0] contention_cnt
);
    localparam int SW = 8;

    logic [SW-1:0]         starve_cnt_reg, starve_cnt_next;
    logic [CNT_WIDTH-1:0]  contention_reg, contention_next;
    logic [ADDR_WIDTH-1:0] last_addr_reg, last_addr_next;
    logic [1:0]            rvalid_reg, rvalid_next;
    logic                  starved;
    logic                  r0_gnt, r1_gnt;
    logic [WIDTH-1:0]      rdata [2];

    // Grants are gated by reset so nothing reaches the BRAM while reset is held.
    assign starved = (starve_cnt_reg == SW'(STARVE_LIMIT));
    assign r1_gnt  = reset & bus.r1_req & (~bus.r0_req | starved);
    assign r0_gnt  = reset & bus.r0_req & ~r1_gnt;

    assign bus.r0_gnt = r0_gnt;
    assign bus.r1_gnt = r1_gnt;

    always_comb begin
        bus.mem_addr   = last_addr_reg;
        bus.mem_we     = 1'b0;
        last_addr_next = last_addr_reg;
        if (r1_gnt) begin
            bus.mem_addr   = bus.r1_addr;
            bus.mem_we     = bus.r1_we;
            last_addr_next = bus.r1_addr;
        end else if (r0_gnt) begin
            bus.mem_addr   = bus.r0_addr;
            last_addr_next = bus.r0_addr;
        end
    end

    assign bus.mem_data = reset ? bus.r1_wdata : '0;

    always_comb begin
        starve_cnt_next = '0;
        if (bus.r1_req && !r1_gnt)
            starve_cnt_next = starved ? starve_cnt_reg : starve_cnt_reg + 1'b1;

        contention_next = contention_reg;
        if (bus.r0_req && bus.r1_req && !(&contention_reg))
            contention_next = contention_reg + 1'b1;

        rvalid_next[0] = r0_gnt;
        rvalid_next[1] = r1_gnt & ~bus.r1_we;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_reg <= '0;
            contention_reg <= '0;
            last_addr_reg  <= '0;
            rvalid_reg     <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            contention_reg <= contention_next;
            last_addr_reg  <= last_addr_next;
            rvalid_reg     <= rvalid_next;
        end
    end

    // The BRAM runs on the inverted clock, so mem_q already holds the word
    // addressed in the grant cycle by the time rvalid rises.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
            assign rdata[gi] = rvalid_reg[gi] ? bus.mem_q : '0;
        end
    endgenerate

    assign bus.r0_rvalid  = rvalid_reg[0];
    assign bus.r1_rvalid  = rvalid_reg[1];
    assign bus.r0_rdata   = rdata[0];
    assign bus.r1_rdata   = rdata[1];
    assign contention_cnt = contention_reg;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: directed scenarios plus a randomized
// run against a cycle-level reference model of arbitration, memory and counters.
module tb_bram_port_arbiter;
    localparam int W       = 16;
    localparam int AW      = 10;
    localparam int LIMIT   = 8;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic [CW-1:0] contention_cnt;

    bram_port_arbiter_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();

    bram_port_arbiter #(
        .WIDTH(W), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .contention_cnt(contention_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM on the inverted clock
    logic [W-1:0] bram [1024];
    always @(negedge clk) begin
        if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_data;
        bus.mem_q <= bram[bus.mem_addr];
    end

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [W-1:0]  ref_mem [1024];
    int            m_starve, m_cont;
    logic [AW-1:0] m_last;
    logic          m_r0v, m_r1v;
    logic [W-1:0]  m_r0d, m_r1d;

    function automatic logic [W-1:0] init_word(input int i);
        return W'((i * 37) ^ 16'h5A00);
    endfunction

    function automatic logic exp_g1();
        return reset && bus.r1_req && (!bus.r0_req || m_starve == LIMIT);
    endfunction

    task automatic model_clear();
        m_starve = 0; m_cont = 0; m_last = '0;
        m_r0v = 1'b0; m_r1v = 1'b0; m_r0d = '0; m_r1d = '0;
    endtask

    // advance the model across the coming edge, then step to just after it
    task automatic tick();
        logic g0, g1;
        g1 = exp_g1();
        g0 = reset && bus.r0_req && !g1;
        if (!reset) begin
            model_clear();
        end else begin
            if (bus.r1_req && !g1) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
            else                   m_starve = 0;
            if (bus.r0_req && bus.r1_req && m_cont < CNT_MAX) m_cont++;
            m_r0v = g0;
            m_r0d = ref_mem[bus.r0_addr];
            m_r1v = g1 && !bus.r1_we;
            m_r1d = ref_mem[bus.r1_addr];
            if (g1)      m_last = bus.r1_addr;
            else if (g0) m_last = bus.r0_addr;
            if (g1 && bus.r1_we) ref_mem[bus.r1_addr] = bus.r1_wdata;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic q0, input logic [AW-1:0] a0, input logic q1,
                         input logic w1, input logic [AW-1:0] a1, input logic [W-1:0] d1);
        bus.r0_req = q0; bus.r0_addr = a0;
        bus.r1_req = q1; bus.r1_we = w1; bus.r1_addr = a1; bus.r1_wdata = d1;
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        drive(0, '0, 0, 0, '0, '0);
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1, 10'h055, 1, 1, 10'h2AA, 16'h1234);
        checks++; if (bus.r0_gnt !== 1'b0) begin errors++; $display("FAIL rst_r0_gnt got=%b exp=0", bus.r0_gnt); end
        checks++; if (bus.r1_gnt !== 1'b0) begin errors++; $display("FAIL rst_r1_gnt got=%b exp=0", bus.r1_gnt); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got=%b exp=0", bus.mem_we); end
        checks++; if (bus.mem_addr !== 10'h000) begin errors++; $display("FAIL rst_mem_addr got=%h exp=000", bus.mem_addr); end
        checks++; if (bus.mem_data !== 16'h0000) begin errors++; $display("FAIL rst_mem_data got=%h exp=0000", bus.mem_data); end
        checks++; if ({bus.r0_rvalid, bus.r1_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid got=%b exp=00", {bus.r0_rvalid, bus.r1_rvalid}); end
        checks++; if ({bus.r0_rdata, bus.r1_rdata} !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", {bus.r0_rdata, bus.r1_rdata}); end
        tick();
        tick();
        checks++; if (contention_cnt !== 4'd0) begin errors++; $display("FAIL rst_contention got=%0d exp=0", contention_cnt); end
        reset = 1'b1;
        drive(0, '0, 0, 0, '0, '0);
        tick();
        checks++; if (contention_cnt !== 4'd0) begin errors++; $display("FAIL rst_contention_after got=%0d exp=0", contention_cnt); end
        $display("txn reset: held low with both requests, released");
    endtask

    task automatic test_r0_read();
        drive(1, 10'h010, 0, 0, '0, '0);
        checks++; if (bus.r0_gnt !== 1'b1) begin errors++; $display("FAIL r0rd_gnt got=%b exp=1", bus.r0_gnt); end
        checks++; if (bus.mem_addr !== 10'h010) begin errors++; $display("FAIL r0rd_mem_addr got=%h exp=010", bus.mem_addr); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL r0rd_mem_we got=%b exp=0", bus.mem_we); end
        checks++; if (bus.r1_gnt !== 1'b0) begin errors++; $display("FAIL r0rd_r1_gnt got=%b exp=0", bus.r1_gnt); end
        tick();
        drive(0, '0, 0, 0, '0, '0);
        checks++; if (bus.r0_rvalid !== 1'b1) begin errors++; $display("FAIL r0rd_rvalid got=%b exp=1", bus.r0_rvalid); end
        checks++; if (bus.r0_rdata !== init_word(16)) begin errors++; $display("FAIL r0rd_rdata got=%h exp=%h", bus.r0_rdata, init_word(16)); end
        checks++; if (bus.r1_gnt !== 1'b0) begin errors++; $display("FAIL r0rd_r1_gnt2 got=%b exp=0", bus.r1_gnt); end
        checks++; if (bus.mem_addr !== 10'h010) begin errors++; $display("FAIL r0rd_addr_hold got=%h exp=010", bus.mem_addr); end
        tick();
        checks++; if (bus.r0_rvalid !== 1'b0) begin errors++; $display("FAIL r0rd_rvalid_drop got=%b exp=0", bus.r0_rvalid); end
        $display("txn r0 read addr=010");
    endtask

    task automatic test_r1_write_read();
        drive(0, '0, 1, 1, 10'h300, 16'hBEEF);
        checks++; if (bus.r1_gnt !== 1'b1) begin errors++; $display("FAIL r1wr_gnt got=%b exp=1", bus.r1_gnt); end
        checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL r1wr_mem_we got=%b exp=1", bus.mem_we); end
        checks++; if (bus.mem_addr !== 10'h300) begin errors++; $display("FAIL r1wr_mem_addr got=%h exp=300", bus.mem_addr); end
        checks++; if (bus.mem_data !== 16'hBEEF) begin errors++; $display("FAIL r1wr_mem_data got=%h exp=BEEF", bus.mem_data); end
        tick();
        drive(0, '0, 1, 0, 10'h300, 16'h0000);
        checks++; if (bus.r1_rvalid !== 1'b0) begin errors++; $display("FAIL r1wr_no_rvalid got=%b exp=0", bus.r1_rvalid); end
        checks++; if (bus.r1_gnt !== 1'b1) begin errors++; $display("FAIL r1rd_gnt got=%b exp=1", bus.r1_gnt); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL r1rd_mem_we got=%b exp=0", bus.mem_we); end
        tick();
        drive(0, '0, 0, 0, '0, '0);
        checks++; if (bus.r1_rvalid !== 1'b1) begin errors++; $display("FAIL r1rd_rvalid got=%b exp=1", bus.r1_rvalid); end
        checks++; if (bus.r1_rdata !== 16'hBEEF) begin errors++; $display("FAIL r1rd_rdata got=%h exp=BEEF", bus.r1_rdata); end
        tick();
        $display("txn r1 write 300=BEEF then read 300");
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 4; c++) begin
            if (c < 3) drive(1, 10'(c), 0, 0, '0, '0);
            else       drive(0, '0, 0, 0, '0, '0);
            if (c < 3) begin
                checks++; if (bus.r0_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt c=%0d got=%b exp=1", c, bus.r0_gnt); end
            end
            if (c > 0) begin
                checks++; if (bus.r0_rvalid !== 1'b1) begin errors++; $display("FAIL b2b_rvalid c=%0d got=%b exp=1", c, bus.r0_rvalid); end
                checks++; if (bus.r0_rdata !== init_word(c - 1)) begin errors++; $display("FAIL b2b_rdata c=%0d got=%h exp=%h", c, bus.r0_rdata, init_word(c - 1)); end
            end
            tick();
        end
        checks++; if (bus.r0_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_rvalid_end got=%b exp=0", bus.r0_rvalid); end
        $display("txn r0 back-to-back reads 000,001,002");
    endtask

    task automatic test_starvation();
        apply_reset();
        for (int c = 0; c <= 20; c++) begin
            logic exp_r1;
            int   exp_cnt;
            exp_r1  = (c == 8) || (c == 17);
            exp_cnt = (c < CNT_MAX) ? c : CNT_MAX;
            drive(1, 10'(c), 1, 0, 10'h300, '0);
            checks++; if (bus.r1_gnt !== exp_r1) begin errors++; $display("FAIL starve_r1_gnt c=%0d got=%b exp=%b", c, bus.r1_gnt, exp_r1); end
            checks++; if (bus.r0_gnt !== !exp_r1) begin errors++; $display("FAIL starve_r0_gnt c=%0d got=%b exp=%b", c, bus.r0_gnt, !exp_r1); end
            checks++; if (contention_cnt !== CW'(exp_cnt)) begin errors++; $display("FAIL starve_contention c=%0d got=%0d exp=%0d", c, contention_cnt, exp_cnt); end
            if (c == 9) begin
                checks++; if (bus.r1_rdata !== 16'hBEEF) begin errors++; $display("FAIL starve_r1_rdata got=%h exp=BEEF", bus.r1_rdata); end
            end
            tick();
        end
        drive(0, '0, 0, 0, '0, '0);
        tick();
        $display("txn starvation: r1 won cycles 8 and 17 under continuous r0");
    endtask

    task automatic test_withdraw();
        for (int c = 0; c <= 14; c++) begin
            logic q1;
            q1 = (c < 3) || (c >= 5);
            if (c < 3) drive(1, 10'(c), q1, 1, 10'h3FF, 16'hDEAD);
            else       drive(1, 10'(c), q1, 0, 10'h3FF, '0);
            checks++; if (bus.r1_gnt !== (c == 13)) begin errors++; $display("FAIL wd_r1_gnt c=%0d got=%b exp=%b", c, bus.r1_gnt, c == 13); end
            if (c < 3) begin
                checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL wd_mem_we c=%0d got=%b exp=0", c, bus.mem_we); end
            end
            if (c == 14) begin
                checks++; if (bus.r1_rvalid !== 1'b1) begin errors++; $display("FAIL wd_r1_rvalid got=%b exp=1", bus.r1_rvalid); end
                checks++; if (bus.r1_rdata !== init_word(10'h3FF)) begin errors++; $display("FAIL wd_r1_rdata got=%h exp=%h", bus.r1_rdata, init_word(10'h3FF)); end
            end
            tick();
        end
        drive(0, '0, 0, 0, '0, '0);
        tick();
        $display("txn withdraw: r1 write withdrawn, later read waited full 8 cycles");
    endtask

    task automatic test_reset_mid();
        drive(0, '0, 1, 0, 10'h300, '0);
        checks++; if (bus.r1_gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt got=%b exp=1", bus.r1_gnt); end
        tick();
        checks++; if (bus.r1_rvalid !== 1'b1) begin errors++; $display("FAIL rmid_rvalid_pre got=%b exp=1", bus.r1_rvalid); end
        reset = 1'b0;
        drive(1, 10'h005, 1, 1, 10'h300, 16'h1234);
        checks++; if (bus.r1_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_rvalid got=%b exp=0", bus.r1_rvalid); end
        checks++; if (bus.r1_rdata !== 16'h0) begin errors++; $display("FAIL rmid_rdata got=%h exp=0", bus.r1_rdata); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rmid_mem_we got=%b exp=0", bus.mem_we); end
        checks++; if (contention_cnt !== 4'd0) begin errors++; $display("FAIL rmid_contention got=%0d exp=0", contention_cnt); end
        tick();
        reset = 1'b1;
        drive(1, 10'h005, 1, 0, 10'h300, '0);
        checks++; if (bus.r0_gnt !== 1'b1) begin errors++; $display("FAIL rmid_resume_r0 got=%b exp=1", bus.r0_gnt); end
        checks++; if (bus.r1_gnt !== 1'b0) begin errors++; $display("FAIL rmid_resume_r1 got=%b exp=0", bus.r1_gnt); end
        tick();
        drive(0, '0, 0, 0, '0, '0);
        checks++; if (contention_cnt !== 4'd1) begin errors++; $display("FAIL rmid_cnt_resume got=%0d exp=1", contention_cnt); end
        checks++; if (bus.r0_rdata !== init_word(5)) begin errors++; $display("FAIL rmid_r0_rdata got=%h exp=%h", bus.r0_rdata, init_word(5)); end
        tick();
        $display("txn reset mid-read: rvalid discarded, arbitration resumed");
    endtask

    task automatic test_random();
        logic          lg0, lg1, eg0, eg1, ewe;
        logic [AW-1:0] eaddr;
        logic [W-1:0]  edata;
        lg0 = 1'b1;
        lg1 = 1'b1;
        for (int c = 0; c < 250; c++) begin
            reset = ($urandom_range(0, 63) != 0);
            if (!bus.r0_req || lg0) begin
                bus.r0_req  = ($urandom_range(0, 2) != 0);
                bus.r0_addr = AW'($urandom_range(0, 31));
            end else if ($urandom_range(0, 15) == 0) begin
                bus.r0_req = 1'b0;
            end
            if (!bus.r1_req || lg1) begin
                bus.r1_req   = ($urandom_range(0, 2) != 0);
                bus.r1_we    = 1'($urandom_range(0, 1));
                bus.r1_addr  = AW'($urandom_range(0, 31));
                bus.r1_wdata = W'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                bus.r1_req = 1'b0;
            end
            #1;
            if (!reset) model_clear();
            eg1   = exp_g1();
            eg0   = reset && bus.r0_req && !eg1;
            eaddr = eg1 ? bus.r1_addr : (eg0 ? bus.r0_addr : m_last);
            ewe   = eg1 && bus.r1_we;
            edata = reset ? bus.r1_wdata : '0;
            checks++; if (bus.r0_gnt !== eg0) begin errors++; $display("FAIL rnd_r0_gnt c=%0d got=%b exp=%b", c, bus.r0_gnt, eg0); end
            checks++; if (bus.r1_gnt !== eg1) begin errors++; $display("FAIL rnd_r1_gnt c=%0d got=%b exp=%b", c, bus.r1_gnt, eg1); end
            checks++; if (bus.mem_addr !== eaddr) begin errors++; $display("FAIL rnd_mem_addr c=%0d got=%h exp=%h", c, bus.mem_addr, eaddr); end
            checks++; if (bus.mem_we !== ewe) begin errors++; $display("FAIL rnd_mem_we c=%0d got=%b exp=%b", c, bus.mem_we, ewe); end
            checks++; if (bus.mem_data !== edata) begin errors++; $display("FAIL rnd_mem_data c=%0d got=%h exp=%h", c, bus.mem_data, edata); end
            checks++; if (bus.r0_rvalid !== m_r0v) begin errors++; $display("FAIL rnd_r0_rvalid c=%0d got=%b exp=%b", c, bus.r0_rvalid, m_r0v); end
            checks++; if (bus.r0_rdata !== (m_r0v ? m_r0d : '0)) begin errors++; $display("FAIL rnd_r0_rdata c=%0d got=%h exp=%h", c, bus.r0_rdata, m_r0v ? m_r0d : '0); end
            checks++; if (bus.r1_rvalid !== m_r1v) begin errors++; $display("FAIL rnd_r1_rvalid c=%0d got=%b exp=%b", c, bus.r1_rvalid, m_r1v); end
            checks++; if (bus.r1_rdata !== (m_r1v ? m_r1d : '0)) begin errors++; $display("FAIL rnd_r1_rdata c=%0d got=%h exp=%h", c, bus.r1_rdata, m_r1v ? m_r1d : '0); end
            checks++; if (contention_cnt !== CW'(m_cont)) begin errors++; $display("FAIL rnd_contention c=%0d got=%0d exp=%0d", c, contention_cnt, m_cont); end
            if (eg0) $display("txn %0d r0 rd addr=%h", c, bus.r0_addr);
            if (eg1) $display("txn %0d r1 %s addr=%h data=%h", c, bus.r1_we ? "wr" : "rd", bus.r1_addr, bus.r1_wdata);
            if (!reset) $display("txn %0d reset pulse", c);
            lg0 = eg0;
            lg1 = eg1;
            tick();
        end
        reset = 1'b1;
        drive(0, '0, 0, 0, '0, '0);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            bram[i]    = init_word(i);
            ref_mem[i] = init_word(i);
        end
        model_clear();
        test_reset();
        test_r0_read();
        test_r1_write_read();
        test_back_to_back();
        test_starvation();
        test_withdraw();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
